// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppu_pkg
// Description : Shared types and constants for the PPU sprite scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package ppu_pkg;

  // Byte address of OAM entry 0 in the CPU memory map
  localparam logic [15:0] OAM_BASE_DEFAULT = 16'hFE00;

  // Scan sequencer states; one FETCH state per OAM byte of an entry
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH_Y    = 3'd1,
    FETCH_X    = 3'd2,
    FETCH_TILE = 3'd3,
    FETCH_ATTR = 3'd4,
    DONE       = 3'd5
  } scan_state_t;

  // One selected sprite, packed as {Y, X, tile, attr}
  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
    logic [7:0] tile;
    logic [7:0] attr;
  } sprite_entry_t;

endpackage
`default_nettype wire

// File: rtl/sprite_y_hit.sv
`default_nettype none
// ============================================================================
// Module      : sprite_y_hit
// Description : Vertical hit test of one sprite against the current line.
//               OAM Y is stored with a +16 bias, so the line is biased to
//               match; 9-bit arithmetic keeps Y near 255 from wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_y_hit
  import ppu_pkg::*;
(
  input  logic [7:0] ly,
  input  logic [7:0] y,
  input  logic       tall,
  output logic       hit
);

  logic [8:0] w_line;
  logic [8:0] w_top;
  logic [8:0] w_bottom;

  assign w_line   = {1'b0, ly} + 9'd16;
  assign w_top    = {1'b0, y};
  assign w_bottom = w_top + (tall ? 9'd16 : 9'd8);
  assign hit      = (w_line >= w_top) && (w_line < w_bottom);

endmodule
`default_nettype wire

// File: rtl/oam_line_scanner.sv
`default_nettype none
// ============================================================================
// Module      : oam_line_scanner
// Description : Walks all OAM entries for one scanline, fetching one byte per
//               accepted request, and stores up to BUFFER_MAX sprites whose
//               Y range covers the line. Extra hits only raise overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module oam_line_scanner
  import ppu_pkg::*;
#(
  parameter int          NUM_SPRITES = 40,
  parameter int          BUFFER_MAX  = 10,
  parameter logic [15:0] OAM_BASE    = OAM_BASE_DEFAULT
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            start_in,
  input  logic [7:0]                      ly_in,
  input  logic                            tall_in,
  output logic [15:0]                     addr_out,
  output logic                            req_out,
  input  logic [7:0]                      data_in,
  input  logic                            data_valid_in,
  input  logic [$clog2(BUFFER_MAX)-1:0]   rd_idx_in,
  output logic [31:0]                     rd_entry_out,
  output logic [$clog2(BUFFER_MAX+1)-1:0] count_out,
  output logic                            busy_out,
  output logic                            done_out,
  output logic                            overflow_out
);

  localparam int IDX_W = $clog2(NUM_SPRITES);
  localparam int CNT_W = $clog2(BUFFER_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_MAX);

  scan_state_t      r_state;
  scan_state_t      w_state_next;

  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_ly;
  logic             r_tall;
  logic [7:0]       r_y;
  logic [7:0]       r_x;
  logic [7:0]       r_tile;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  sprite_entry_t    r_buf [BUFFER_MAX];

  logic             w_hit;
  logic             w_full;
  logic             w_start;
  logic             w_latch_y;
  logic             w_latch_x;
  logic             w_latch_tile;
  logic             w_write;
  logic             w_advance;
  logic             w_set_ovf;
  logic [1:0]       w_k;

  // The Y byte is tested straight off the read bus in the cycle it arrives
  sprite_y_hit u_y_hit (
    .ly   (r_ly),
    .y    (data_in),
    .tall (r_tall),
    .hit  (w_hit)
  );

  assign w_full       = (r_count == CNT_FULL);
  assign busy_out     = (r_state != IDLE);
  assign done_out     = (r_state == DONE);
  assign count_out    = r_count;
  assign overflow_out = r_overflow;
  assign rd_entry_out = (int'(rd_idx_in) < BUFFER_MAX) ? r_buf[rd_idx_in] : 32'h0;

  // State register; reset aborts any scan in progress
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, request outputs and datapath strobes
  always_comb begin
    w_state_next = r_state;
    req_out      = 1'b0;
    w_k          = 2'd0;
    w_start      = 1'b0;
    w_latch_y    = 1'b0;
    w_latch_x    = 1'b0;
    w_latch_tile = 1'b0;
    w_write      = 1'b0;
    w_advance    = 1'b0;
    w_set_ovf    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_in) begin
          w_start      = 1'b1;
          w_state_next = FETCH_Y;
        end
      end
      FETCH_Y: begin
        req_out = 1'b1;
        w_k     = 2'd0;
        if (data_valid_in) begin
          if (w_hit && !w_full) begin
            w_latch_y    = 1'b1;
            w_state_next = FETCH_X;
          end else begin
            // Once full, hits are only flagged; the rest of the entry is skipped
            w_set_ovf = w_hit;
            w_advance = 1'b1;
          end
        end
      end
      FETCH_X: begin
        req_out = 1'b1;
        w_k     = 2'd1;
        if (data_valid_in) begin
          w_latch_x    = 1'b1;
          w_state_next = FETCH_TILE;
        end
      end
      FETCH_TILE: begin
        req_out = 1'b1;
        w_k     = 2'd2;
        if (data_valid_in) begin
          w_latch_tile = 1'b1;
          w_state_next = FETCH_ATTR;
        end
      end
      FETCH_ATTR: begin
        req_out = 1'b1;
        w_k     = 2'd3;
        if (data_valid_in) begin
          w_write   = 1'b1;
          w_advance = 1'b1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    if (w_advance) begin
      w_state_next = (r_idx == LAST_IDX) ? DONE : FETCH_Y;
    end
    addr_out = req_out ? (OAM_BASE + (16'(r_idx) << 2) + 16'(w_k)) : 16'h0000;
  end

  // Scan context, fetched bytes, entry count and sticky overflow
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_idx      <= '0;
      r_ly       <= 8'h00;
      r_tall     <= 1'b0;
      r_y        <= 8'h00;
      r_x        <= 8'h00;
      r_tile     <= 8'h00;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_start) begin
        r_ly       <= ly_in;
        r_tall     <= tall_in;
        r_idx      <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end
      if (w_latch_y) begin
        r_y <= data_in;
      end
      if (w_latch_x) begin
        r_x <= data_in;
      end
      if (w_latch_tile) begin
        r_tile <= data_in;
      end
      if (w_write) begin
        r_count <= r_count + CNT_W'(1);
      end
      if (w_set_ovf) begin
        r_overflow <= 1'b1;
      end
      if (w_advance && (r_idx != LAST_IDX)) begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  // Sprite buffer; count_out alone marks which slots are meaningful
  always_ff @(posedge clk_in) begin
    if (w_write) begin
      r_buf[r_count] <= {r_y, r_x, r_tile, data_in};
    end
  end

endmodule
`default_nettype wire

// File: doc/oam_line_scanner.md
OAM_LINE_SCANNER -- requirements
Module: oam_line_scanner

Interface
REQ-001 Parameter NUM_SPRITES, default 40, SHALL be the number of OAM entries scanned per line.
REQ-002 Parameter BUFFER_MAX, default 10, SHALL be the maximum number of selected sprites stored.
REQ-003 Parameter OAM_BASE, default 16'hFE00, SHALL be the byte address of OAM entry 0.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port: clk_in, input, 1, system clock.
REQ-006 Port: rst_in, input, 1, synchronous active-high reset.
REQ-007 Port: start_in, input, 1, single-cycle pulse that begins a scan.
REQ-008 Port: ly_in, input, 8, current scanline, sampled on start.
REQ-009 Port: tall_in, input, 1, 8x16 sprite mode (LCDC bit 2), sampled on start.
REQ-010 Port: addr_out, output, 16, OAM byte address being requested.
REQ-011 Port: req_out, output, 1, read request; addr_out is valid while high.
REQ-012 Port: data_in, input, 8, read data.
REQ-013 Port: data_valid_in, input, 1, data_in is valid for the outstanding request.
REQ-014 Port: rd_idx_in, input, $clog2(BUFFER_MAX), buffer read index.
REQ-015 Port: rd_entry_out, output, 32, {Y, X, tile, attr} of the entry at rd_idx_in, combinational read.
REQ-016 Port: count_out, output, $clog2(BUFFER_MAX+1), number of stored entries.
REQ-017 Port: busy_out, output, 1, high while a scan is in progress.
REQ-018 Port: done_out, output, 1, one-cycle pulse at scan completion.
REQ-019 Port: overflow_out, output, 1, a hit occurred while the buffer was full.

Function
REQ-020 The FSM SHALL have the states IDLE, FETCH_Y, FETCH_X, FETCH_TILE, FETCH_ATTR and DONE.
REQ-021 In IDLE, start_in SHALL latch ly_in and tall_in, clear count_out and overflow_out, set the sprite index to 0, and enter FETCH_Y.
REQ-022 start_in SHALL be ignored outside IDLE.
REQ-023 In each FETCH state, req_out SHALL be 1 and addr_out SHALL equal OAM_BASE + 4*index + k, with k = 0, 1, 2, 3 for Y, X, tile and attr respectively.
REQ-024 One byte SHALL be accepted per cycle in which req_out and data_valid_in are both high; data_valid_in with req_out low SHALL be ignored.
REQ-025 Throughput SHALL be at most one byte per cycle; the next request SHALL be presented the cycle after acceptance.
REQ-026 Hit test, in 9-bit unsigned arithmetic: (ly+16 >= Y) and (ly+16 < Y + (tall ? 16 : 8)).
REQ-027 The X value SHALL NOT affect selection; X = 0 sprites SHALL be stored and counted.
REQ-028 A hit with count_out < BUFFER_MAX SHALL fetch X, tile and attr, write the entry at slot count_out in the cycle attr is accepted, and increment count_out in that same cycle.
REQ-029 A miss SHALL advance the index and return to FETCH_Y.
REQ-030 A hit with count_out == BUFFER_MAX SHALL set overflow_out (sticky until the next start) and fetch only Y bytes for the remainder of the scan.
REQ-031 After the final byte of sprite NUM_SPRITES-1, the FSM SHALL enter DONE, assert done_out for exactly 1 cycle, and return to IDLE.
REQ-032 busy_out SHALL equal (state != IDLE).
REQ-033 Buffer contents and count_out SHALL be held after DONE until the next accepted start.
REQ-034 rd_entry_out for rd_idx_in >= count_out SHALL be don't-care.

Reset
REQ-035 rst_in SHALL force the FSM to IDLE and set req_out, busy_out, done_out, overflow_out, count_out and addr_out to 0 on the next clock edge, aborting any scan in progress.
REQ-036 Buffer storage SHALL NOT require reset; count_out = 0 SHALL mark it empty.

Structure
REQ-037 Package ppu_pkg SHALL hold the OAM_BASE default, the scan_state_t enum and the sprite_entry_t struct {y, x, tile, attr}.
REQ-038 The hit test SHALL be a sub-module, sprite_y_hit, with inputs ly, y, tall and output hit.

Verification
REQ-039 ly=0, tall=0, sprite 0 Y=16 X=8, all other Y=0, valid 1 cycle after each req -> count_out=1, entry 0 = {16, 8, tile, attr}, done_out pulses once, no overflow.
REQ-040 ly=7 with Y=16 -> hit; ly=8, tall=0 -> miss; ly=8, tall=1 -> hit; ly=15, tall=1 -> hit; ly=16, tall=1 -> miss.
REQ-041 All 40 sprites Y=20, ly=10 -> count_out=10, overflow_out=1, entries 0-9 from sprites 0-9 in OAM order, sprites 10-39 fetch Y only.
REQ-042 Random 0-5 cycle data_valid_in delays -> same results as the zero-delay run; addr_out is stable while req_out is high.
REQ-043 rst_in asserted mid-FETCH_X -> the next cycle is IDLE with all outputs 0; a fresh start_in then completes normally.
REQ-044 start_in pulsed while busy_out=1 -> ignored; count_out continues uninterrupted.
